// File: rtl/sdr_16_responder_if.sv
// sdr_16_responder_if: command/address/data bus between an SDRAM controller and the x16 SDR responder.
interface sdr_16_responder_if;
   logic [2:0]  cmd;
   logic [1:0]  ba;
   logic [12:0] a;
   logic [1:0]  dqm;
   logic [15:0] dq_i;
   logic [15:0] dq_o;
   logic        dq_oe_o;
   logic        mode_valid;
   logic [4:0]  err;
   modport master (output cmd, ba, a, dqm, dq_i, input dq_o, dq_oe_o, mode_valid, err);
   modport slave (input cmd, ba, a, dqm, dq_i, output dq_o, dq_oe_o, mode_valid, err);
endinterface

// File: rtl/sdr_16_responder.sv
// sdr_16_responder: single-rank x16 SDR SDRAM device model with mode register, bank/row tracking,
// CAS-latency read bursts, masked write bursts and sticky protocol-error flags.
module sdr_16_responder #(
   parameter int ROW_W = 3,
   parameter int COL_W = 5,
   parameter int MEM_AW = 2 + ROW_W + COL_W
) (
   input logic sdram_clk,
   input logic sdram_rst,
   sdr_16_responder_if.slave bus
);
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PCH = 3'b010;
   localparam logic [2:0] CMD_RFR = 3'b001;
   localparam logic [2:0] CMD_LMR = 3'b000;
   logic [15:0] mem [2**MEM_AW];
   logic [2:0] cl;
   logic [1:0] blc;
   logic wb;
   logic [3:0] open_bank;
   logic [ROW_W-1:0] open_row [4];
   logic b_act, b_wr;
   logic [1:0] b_ba;
   logic [ROW_W-1:0] b_row;
   logic [COL_W-1:0] b_c, b_n;
   logic p0_v, p1_v;
   logic [15:0] rd_data, p1_d;
   logic [1:0] dqm_d;
   logic mode_ok, start, cont, iss, iss_wr, src_v;
   logic [1:0] iss_ba;
   logic [ROW_W-1:0] iss_row;
   logic [COL_W-1:0] iss_c, iss_n, bl_m, col;
   logic [MEM_AW-1:0] addr;
   logic [15:0] src_d;
   logic unused_a;
   assign unused_a = ^bus.a;
   // A beat is issued on the rd/wr edge itself and on each following edge until BL beats or interruption.
   always_comb begin
      mode_ok = (bus.a[6:4] == 3'd2 || bus.a[6:4] == 3'd3) && !bus.a[3] && !bus.a[2];
      start = (bus.cmd == CMD_RD || bus.cmd == CMD_WR) && bus.mode_valid && open_bank[bus.ba] && !bus.a[10];
      cont = b_act && !start && bus.cmd != CMD_PCH;
      iss = start || cont;
      iss_wr = start ? bus.cmd == CMD_WR : b_wr;
      iss_ba = start ? bus.ba : b_ba;
      iss_row = start ? open_row[bus.ba] : b_row;
      iss_c = start ? bus.a[COL_W-1:0] : b_c;
      iss_n = start ? '0 : b_n;
      bl_m = COL_W'((32'd1 << blc) - 32'd1);
      col = (iss_c & ~bl_m) | ((iss_c + iss_n) & bl_m);
      addr = {iss_ba, iss_row, col};
      src_v = cl == 3'd3 ? p1_v : p0_v;
      src_d = cl == 3'd3 ? p1_d : rd_data;
   end
   always_ff @(posedge sdram_clk) begin
      if (iss && iss_wr && !bus.dqm[0]) mem[addr][7:0] <= bus.dq_i[7:0];
      if (iss && iss_wr && !bus.dqm[1]) mem[addr][15:8] <= bus.dq_i[15:8];
      rd_data <= mem[addr];
      p1_d <= rd_data;
   end
   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         bus.dq_o <= '0;
         bus.dq_oe_o <= 1'b0;
         bus.mode_valid <= 1'b0;
         bus.err <= '0;
         cl <= 3'd2;
         blc <= '0;
         wb <= 1'b0;
         open_bank <= '0;
         for (int i = 0; i < 4; i++) open_row[i] <= '0;
         b_act <= 1'b0;
         b_wr <= 1'b0;
         b_ba <= '0;
         b_row <= '0;
         b_c <= '0;
         b_n <= '0;
         p0_v <= 1'b0;
         p1_v <= 1'b0;
         dqm_d <= '0;
      end else begin
         dqm_d <= bus.dqm;
         p0_v <= iss && !iss_wr;
         p1_v <= p0_v;
         // Read dqm is applied one edge late so it lines up with the beat the controller samples two edges on.
         if (src_v && dqm_d != 2'b11) begin
            bus.dq_oe_o <= 1'b1;
            if (!dqm_d[0]) bus.dq_o[7:0] <= src_d[7:0];
            if (!dqm_d[1]) bus.dq_o[15:8] <= src_d[15:8];
         end else
            bus.dq_oe_o <= 1'b0;
         if (start) begin
            b_act <= blc != 2'd0 && !(bus.cmd == CMD_WR && wb);
            b_wr <= bus.cmd == CMD_WR;
            b_ba <= bus.ba;
            b_row <= open_row[bus.ba];
            b_c <= bus.a[COL_W-1:0];
            b_n <= COL_W'(1);
         end else if (cont) begin
            b_act <= b_n != bl_m;
            b_n <= b_n + 1'b1;
         end else
            b_act <= 1'b0;
         case (bus.cmd)
            CMD_LMR:
               if (mode_ok) begin
                  cl <= bus.a[6:4];
                  blc <= bus.a[1:0];
                  wb <= bus.a[9];
                  bus.mode_valid <= 1'b1;
               end else
                  bus.err[4] <= 1'b1;
            CMD_ACT:
               if (!bus.mode_valid)
                  bus.err[0] <= 1'b1;
               else begin
                  if (open_bank[bus.ba]) bus.err[1] <= 1'b1;
                  open_bank[bus.ba] <= 1'b1;
                  open_row[bus.ba] <= bus.a[ROW_W-1:0];
               end
            CMD_PCH:
               if (bus.a[10]) open_bank <= '0;
               else open_bank[bus.ba] <= 1'b0;
            CMD_RFR:
               if (|open_bank) bus.err[3] <= 1'b1;
            CMD_RD, CMD_WR:
               if (!bus.mode_valid) bus.err[0] <= 1'b1;
               else if (!open_bank[bus.ba]) bus.err[2] <= 1'b1;
               else if (bus.a[10]) bus.err[4] <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sdr_16_responder.sv
// tb_sdr_16_responder: directed-vector bench for the x16 SDR responder with hand-computed expectations.
module tb_sdr_16_responder;
   localparam logic [2:0] NOP = 3'b111;
   localparam logic [2:0] ACT = 3'b011;
   localparam logic [2:0] RD  = 3'b101;
   localparam logic [2:0] WR  = 3'b100;
   localparam logic [2:0] PCH = 3'b010;
   localparam logic [2:0] RFR = 3'b001;
   localparam logic [2:0] LMR = 3'b000;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int failures = 0;
   sdr_16_responder_if bus ();
   sdr_16_responder dut (.sdram_clk(clk), .sdram_rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // Drive one command between edges; return just after the edge that samples it.
   task automatic tick(input logic [2:0] c, input logic [1:0] b, input logic [12:0] ad, input logic [1:0] m, input logic [15:0] d);
      @(negedge clk);
      bus.cmd = c;
      bus.ba = b;
      bus.a = ad;
      bus.dqm = m;
      bus.dq_i = d;
      @(posedge clk);
      #1;
   endtask
   task automatic nop;
      tick(NOP, 2'd0, 13'd0, 2'b00, 16'h0000);
   endtask
   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      bus.cmd = NOP;
      bus.ba = '0;
      bus.a = '0;
      bus.dqm = '0;
      bus.dq_i = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask
   logic [15:0] exp_rd4 [4] = '{16'h3333, 16'h4444, 16'h1111, 16'h2222};
   logic [15:0] exp_wb [4] = '{16'hBEEF, 16'h0209, 16'h020A, 16'h020B};
   logic [15:0] wdat [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
   initial begin
      bus.cmd = NOP;
      bus.ba = '0;
      bus.a = '0;
      bus.dqm = '0;
      bus.dq_i = '0;
      #2;
      do_reset();
      check("rst_dq", bus.dq_o, 16'h0000);
      check("rst_oe", 16'(bus.dq_oe_o), 16'd0);
      check("rst_mv", 16'(bus.mode_valid), 16'd0);
      check("rst_err", 16'(bus.err), 16'd0);
      tick(RD, 2'd0, 13'd0, 2'b00, 16'h0);
      nop();
      check("err_before_lmr", 16'(bus.err), 16'b00001);
      // CL2 BL4: write col4..7 then read from col6, wrapping in the 4-aligned block
      do_reset();
      tick(LMR, 2'd0, 13'h022, 2'b00, 16'h0);
      check("mv_set", 16'(bus.mode_valid), 16'd1);
      tick(ACT, 2'd1, 13'd5, 2'b00, 16'h0);
      for (int i = 0; i < 4; i++) tick(i == 0 ? WR : NOP, 2'd1, 13'd4, 2'b00, wdat[i]);
      tick(RD, 2'd1, 13'd6, 2'b00, 16'h0);
      check("cl2_oe_rd_edge", 16'(bus.dq_oe_o), 16'd0);
      for (int i = 0; i < 4; i++) begin
         nop();
         check("cl2_oe_beat", 16'(bus.dq_oe_o), 16'd1);
         check("cl2_dq_beat", bus.dq_o, exp_rd4[i]);
      end
      nop();
      check("cl2_oe_end", 16'(bus.dq_oe_o), 16'd0);
      check("cl2_err", 16'(bus.err), 16'd0);
      // CL3 BL1 with lower-byte write mask
      tick(LMR, 2'd0, 13'h030, 2'b00, 16'h0);
      tick(WR, 2'd1, 13'd0, 2'b00, 16'h0000);
      tick(WR, 2'd1, 13'd0, 2'b01, 16'hABCD);
      tick(RD, 2'd1, 13'd0, 2'b00, 16'h0);
      nop();
      check("cl3_oe_early", 16'(bus.dq_oe_o), 16'd0);
      nop();
      check("cl3_oe", 16'(bus.dq_oe_o), 16'd1);
      check("cl3_dq_masked_wr", bus.dq_o, 16'hAB00);
      nop();
      check("cl3_oe_end", 16'(bus.dq_oe_o), 16'd0);
      tick(WR, 2'd1, 13'd1, 2'b00, 16'h5555);
      tick(RD, 2'd1, 13'd1, 2'b00, 16'h0);
      tick(NOP, 2'd0, 13'd0, 2'b11, 16'h0);
      nop();
      check("rd_dqm_oe", 16'(bus.dq_oe_o), 16'd0);
      check("rd_dqm_dq_hold", bus.dq_o, 16'hAB00);
      nop();
      check("rd_dqm_oe_after", 16'(bus.dq_oe_o), 16'd0);
      // CL2 BL8 interrupted read
      tick(LMR, 2'd0, 13'h023, 2'b00, 16'h0);
      tick(ACT, 2'd2, 13'd3, 2'b00, 16'h0);
      for (int i = 0; i < 8; i++) tick(i == 0 ? WR : NOP, 2'd2, 13'd0, 2'b00, 16'(16'h0100 + i));
      for (int i = 0; i < 8; i++) tick(i == 0 ? WR : NOP, 2'd2, 13'd16, 2'b00, 16'(16'h0110 + i));
      tick(RD, 2'd2, 13'd0, 2'b00, 16'h0);
      for (int i = 0; i < 11; i++) begin
         if (i == 2) tick(RD, 2'd2, 13'd16, 2'b00, 16'h0);
         else nop();
         check("intr_oe", 16'(bus.dq_oe_o), 16'd1);
         check("intr_dq", bus.dq_o, i < 3 ? 16'(16'h0100 + i) : 16'(16'h0110 + i - 3));
      end
      nop();
      check("intr_oe_end", 16'(bus.dq_oe_o), 16'd0);
      // Error flags accumulate
      tick(ACT, 2'd2, 13'd3, 2'b00, 16'h0);
      nop();
      check("err_act_open", 16'(bus.err), 16'b00010);
      tick(RD, 2'd3, 13'd0, 2'b00, 16'h0);
      nop();
      check("err_rd_closed", 16'(bus.err), 16'b00110);
      tick(RFR, 2'd0, 13'd0, 2'b00, 16'h0);
      nop();
      check("err_rfr_open", 16'(bus.err), 16'b01110);
      tick(LMR, 2'd0, 13'h027, 2'b00, 16'h0);
      nop();
      check("err_bad_lmr", 16'(bus.err), 16'b11110);
      tick(RD, 2'd2, 13'd0, 2'b00, 16'h0);
      nop();
      check("mode_kept_first", bus.dq_o, 16'h0100);
      for (int i = 0; i < 7; i++) nop();
      check("mode_kept_oe8", 16'(bus.dq_oe_o), 16'd1);
      check("mode_kept_last", bus.dq_o, 16'h0107);
      nop();
      check("mode_kept_end", 16'(bus.dq_oe_o), 16'd0);
      // Single-location writes, then precharge-all
      do_reset();
      tick(LMR, 2'd0, 13'h022, 2'b00, 16'h0);
      tick(ACT, 2'd2, 13'd3, 2'b00, 16'h0);
      for (int i = 0; i < 4; i++) tick(i == 0 ? WR : NOP, 2'd2, 13'd8, 2'b00, 16'(16'h0208 + i));
      tick(LMR, 2'd0, 13'h222, 2'b00, 16'h0);
      tick(WR, 2'd2, 13'd8, 2'b00, 16'hBEEF);
      for (int i = 0; i < 3; i++) tick(NOP, 2'd0, 13'd0, 2'b00, 16'hDEAD);
      tick(RD, 2'd2, 13'd8, 2'b00, 16'h0);
      for (int i = 0; i < 4; i++) begin
         nop();
         check("wb_dq", bus.dq_o, exp_wb[i]);
      end
      check("wb_err", 16'(bus.err), 16'd0);
      tick(PCH, 2'd0, 13'h400, 2'b00, 16'h0);
      tick(RD, 2'd2, 13'd8, 2'b00, 16'h0);
      nop();
      check("pch_all_err", 16'(bus.err), 16'b00100);
      nop();
      check("pch_all_no_rd", 16'(bus.dq_oe_o), 16'd0);
      // Reset in the middle of a BL8 read
      tick(LMR, 2'd0, 13'h023, 2'b00, 16'h0);
      tick(ACT, 2'd2, 13'd3, 2'b00, 16'h0);
      tick(RD, 2'd2, 13'd0, 2'b00, 16'h0);
      nop();
      nop();
      check("pre_rst_oe", 16'(bus.dq_oe_o), 16'd1);
      @(negedge clk);
      bus.cmd = NOP;
      rst = 1'b1;
      #1;
      check("rst_mid_oe", 16'(bus.dq_oe_o), 16'd0);
      check("rst_mid_mv", 16'(bus.mode_valid), 16'd0);
      check("rst_mid_dq", bus.dq_o, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         nop();
         check("post_rst_oe", 16'(bus.dq_oe_o), 16'd0);
      end
      check("post_rst_mv", 16'(bus.mode_valid), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
